// File: rtl/map_recovery_ctrl_if.sv
// Bundle between the recovery sequencer, the ROB/arch-map side and the
// map-table write ports. "master" is the sequencer's view.
interface map_recovery_ctrl_if #(
  parameter int NUM_PR     = 64,
  parameter int NUM_ARCH   = 32,
  parameter int COPY_WIDTH = 4
);
  localparam int TW = $clog2(NUM_PR);
  localparam int IW = $clog2(NUM_ARCH);

  logic                                en;
  logic                                flush_req;
  logic [NUM_ARCH-1:0][TW-1:0]         arch_map_in;
  logic [COPY_WIDTH-1:0]               mt_wr_en;
  logic [COPY_WIDTH-1:0][IW-1:0]       mt_wr_idx;
  logic [COPY_WIDTH-1:0][TW-1:0]       mt_wr_pr;
  logic                                stall_dispatch;
  logic                                busy;
  logic                                done;
  logic                                dropped_flush;

  modport master (
    input  en, flush_req, arch_map_in,
    output mt_wr_en, mt_wr_idx, mt_wr_pr, stall_dispatch, busy, done, dropped_flush
  );

  modport slave (
    output en, flush_req, arch_map_in,
    input  mt_wr_en, mt_wr_idx, mt_wr_pr, stall_dispatch, busy, done, dropped_flush
  );
endinterface

// File: rtl/map_recovery_ctrl.sv
// Restores the speculative map table from a snapshot of the arch map after a
// flush: one settle cycle, then COPY_WIDTH entries per cycle, then a done pulse.

// One map-table write lane: decodes its arch index from the block counter and
// picks the matching snapshot entry. Outputs are zero outside COPY.
module map_recovery_lane #(
  parameter int LANE     = 0,
  parameter int CW       = 4,
  parameter int NUM_ARCH = 32,
  parameter int TW       = 6,
  parameter int IW       = 5,
  parameter int BW       = 3
) (
  input  logic                        act,
  input  logic                        wen,
  input  logic [BW-1:0]               blk,
  input  logic [NUM_ARCH-1:0][TW-1:0] snapshot,
  output logic                        wr_en,
  output logic [IW-1:0]               wr_idx,
  output logic [TW-1:0]               wr_pr
);
  logic [IW-1:0] idx;

  assign idx    = IW'(int'(blk) * CW + LANE);
  assign wr_en  = act & wen;
  assign wr_idx = act ? idx : '0;
  assign wr_pr  = act ? snapshot[idx] : '0;
endmodule

module map_recovery_ctrl #(
  parameter int NUM_PR     = 64,
  parameter int NUM_ARCH   = 32,
  parameter int COPY_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  map_recovery_ctrl_if.master bus
);
  localparam int TW   = $clog2(NUM_PR);
  localparam int IW   = $clog2(NUM_ARCH);
  localparam int NBLK = NUM_ARCH / COPY_WIDTH;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(NBLK - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COPY, DONE} state_t;

  state_t                      state, state_nxt;
  logic [BW-1:0]               blk, blk_nxt;
  logic                        snap_ld;
  logic [NUM_ARCH-1:0][TW-1:0] snapshot;
  logic                        dropped;

  logic [COPY_WIDTH-1:0]         wr_en;
  logic [COPY_WIDTH-1:0][IW-1:0] wr_idx;
  logic [COPY_WIDTH-1:0][TW-1:0] wr_pr;

  // State, block counter, snapshot and sticky drop flag; everything freezes while en is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      blk      <= '0;
      snapshot <= '0;
      dropped  <= 1'b0;
    end else if (bus.en) begin
      state <= state_nxt;
      blk   <= blk_nxt;
      if (snap_ld) snapshot <= bus.arch_map_in;
      // A flush while a restore is in flight (incl. the done cycle) is lost.
      if (bus.flush_req && state != IDLE) dropped <= 1'b1;
    end
  end

  // Next-state / counter logic; the snapshot is taken on the SETTLE->COPY edge
  // so the final retire has already landed in the arch map.
  always_comb begin
    state_nxt = state;
    blk_nxt   = blk;
    snap_ld   = 1'b0;
    case (state)
      IDLE:   if (bus.flush_req) state_nxt = SETTLE;
      SETTLE: begin
        state_nxt = COPY;
        snap_ld   = 1'b1;
      end
      COPY: begin
        if (blk == BLK_LAST) begin
          state_nxt = DONE;
          blk_nxt   = '0;
        end else begin
          blk_nxt = blk + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < COPY_WIDTH; i++) begin : g_lane
    map_recovery_lane #(
      .LANE(i), .CW(COPY_WIDTH), .NUM_ARCH(NUM_ARCH), .TW(TW), .IW(IW), .BW(BW)
    ) u_lane (
      .act      (state == COPY),
      .wen      (bus.en),
      .blk      (blk),
      .snapshot (snapshot),
      .wr_en    (wr_en[i]),
      .wr_idx   (wr_idx[i]),
      .wr_pr    (wr_pr[i])
    );
  end

  // Status outputs decode straight from state; done stays up while en is low.
  assign bus.mt_wr_en       = wr_en;
  assign bus.mt_wr_idx      = wr_idx;
  assign bus.mt_wr_pr       = wr_pr;
  assign bus.busy           = (state != IDLE);
  assign bus.stall_dispatch = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.dropped_flush  = dropped;
endmodule

// File: tb/tb_map_recovery_ctrl.sv
// Directed bench for map_recovery_ctrl with default parameters.
module tb_map_recovery_ctrl;
  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int CW       = 4;
  localparam int TW       = 6;
  localparam int IW       = 5;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  map_recovery_ctrl_if #(.NUM_PR(NUM_PR), .NUM_ARCH(NUM_ARCH), .COPY_WIDTH(CW)) bus ();

  map_recovery_ctrl #(.NUM_PR(NUM_PR), .NUM_ARCH(NUM_ARCH), .COPY_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, want finish before 100000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [CW-1:0][IW-1:0] exp_idx(int b);
    logic [CW-1:0][IW-1:0] r;
    for (int i = 0; i < CW; i++) r[i] = IW'(b * CW + i);
    return r;
  endfunction

  // Expected PR for block b when arch_map[k] = base + k (or base - k).
  function automatic logic [CW-1:0][TW-1:0] exp_pr(int b, int base, bit down);
    logic [CW-1:0][TW-1:0] r;
    for (int i = 0; i < CW; i++) r[i] = TW'(down ? base - (b * CW + i) : base + (b * CW + i));
    return r;
  endfunction

  task automatic test_reset();
    bus.en = 1'b1; bus.flush_req = 1'b0; bus.arch_map_in = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (bus.mt_wr_en !== '0 || bus.mt_wr_idx !== '0 || bus.mt_wr_pr !== '0 || bus.busy !== 1'b0 ||
          bus.stall_dispatch !== 1'b0 || bus.done !== 1'b0 || bus.dropped_flush !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: wr_en=%b idx=%h pr=%h busy=%b stall=%b done=%b drop=%b, want all 0",
                 c, bus.mt_wr_en, bus.mt_wr_idx, bus.mt_wr_pr, bus.busy, bus.stall_dispatch, bus.done, bus.dropped_flush);
      end
    end
  endtask

  // Full restore; arch map is overwritten mid-COPY to prove the snapshot is used.
  task automatic test_copy();
    int wcnt[NUM_ARCH];
    int busy_cyc = 0, done_cyc = 0, bad = 0;
    logic [CW-1:0] ew;
    for (int k = 0; k < NUM_ARCH; k++) begin bus.arch_map_in[k] = TW'(k + 32); wcnt[k] = 0; end
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) for (int k = 0; k < NUM_ARCH; k++) bus.arch_map_in[k] = TW'(5);
      #1;
      ew = (c >= 1 && c <= 8) ? '1 : '0;
      vectors++;
      if (bus.mt_wr_en !== ew || bus.busy !== (c <= 9) || bus.stall_dispatch !== (c <= 9) || bus.done !== (c == 9)) begin
        miscompares++;
        $display("FAIL copy_ctl cyc %0d: wr_en=%b busy=%b stall=%b done=%b, want wr_en=%b busy=%b done=%b",
                 c, bus.mt_wr_en, bus.busy, bus.stall_dispatch, bus.done, ew, (c <= 9), (c == 9));
      end
      vectors++;
      if (ew != '0) begin
        if (bus.mt_wr_idx !== exp_idx(c - 1) || bus.mt_wr_pr !== exp_pr(c - 1, 32, 1'b0)) begin
          miscompares++;
          $display("FAIL copy_data cyc %0d: idx=%h pr=%h, want idx=%h pr=%h",
                   c, bus.mt_wr_idx, bus.mt_wr_pr, exp_idx(c - 1), exp_pr(c - 1, 32, 1'b0));
        end
        for (int i = 0; i < CW; i++) if (bus.mt_wr_en[i]) wcnt[int'(bus.mt_wr_idx[i])]++;
      end else if (bus.mt_wr_idx !== '0 || bus.mt_wr_pr !== '0) begin
        miscompares++;
        $display("FAIL copy_zero cyc %0d: idx=%h pr=%h, want 0", c, bus.mt_wr_idx, bus.mt_wr_pr);
      end
      busy_cyc += int'(bus.busy); done_cyc += int'(bus.done);
      tick();
    end
    for (int k = 0; k < NUM_ARCH; k++) if (wcnt[k] != 1) bad++;
    vectors++;
    if (busy_cyc != 10 || done_cyc != 1 || bad != 0) begin
      miscompares++;
      $display("FAIL copy_totals: busy_cycles=%0d done_pulses=%0d bad_idx=%0d, want 10 1 0", busy_cyc, done_cyc, bad);
    end
  endtask

  // en low for 3 cycles while blk=3: no writes, blk holds, resume at 12-15.
  task automatic test_en_stall();
    int wcnt[NUM_ARCH];
    int eb, bad = 0;
    logic [CW-1:0] ew;
    for (int k = 0; k < NUM_ARCH; k++) begin bus.arch_map_in[k] = TW'(63 - k); wcnt[k] = 0; end
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
    for (int c = 0; c < 14; c++) begin
      bus.en = !(c >= 4 && c <= 6);
      #1;
      eb = (c <= 3) ? c - 1 : (c <= 7) ? 3 : c - 4;
      ew = (c >= 1 && c <= 11 && bus.en) ? '1 : '0;
      vectors++;
      if (bus.mt_wr_en !== ew || bus.busy !== (c <= 12) || bus.done !== (c == 12)) begin
        miscompares++;
        $display("FAIL en_ctl cyc %0d: wr_en=%b busy=%b done=%b, want wr_en=%b busy=%b done=%b",
                 c, bus.mt_wr_en, bus.busy, bus.done, ew, (c <= 12), (c == 12));
      end
      if (c >= 1 && c <= 11) begin
        vectors++;
        if (bus.mt_wr_idx !== exp_idx(eb) || bus.mt_wr_pr !== exp_pr(eb, 63, 1'b1)) begin
          miscompares++;
          $display("FAIL en_data cyc %0d: idx=%h pr=%h, want idx=%h pr=%h",
                   c, bus.mt_wr_idx, bus.mt_wr_pr, exp_idx(eb), exp_pr(eb, 63, 1'b1));
        end
        for (int i = 0; i < CW; i++) if (bus.mt_wr_en[i]) wcnt[int'(bus.mt_wr_idx[i])]++;
      end
      tick();
    end
    bus.en = 1'b1;
    for (int k = 0; k < NUM_ARCH; k++) if (wcnt[k] != 1) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL en_writes: %0d indices not written exactly once, want 0", bad);
    end
  endtask

  // Second flush during COPY: ignored, copy unaffected, sticky flag set.
  task automatic test_dropped();
    logic [CW-1:0] ew;
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
    for (int c = 0; c < 14; c++) begin
      bus.flush_req = (c == 4);
      #1;
      ew = (c >= 1 && c <= 8) ? '1 : '0;
      vectors++;
      if (bus.mt_wr_en !== ew || bus.dropped_flush !== (c >= 5) || bus.done !== (c == 9) || bus.busy !== (c <= 9)) begin
        miscompares++;
        $display("FAIL drop_ctl cyc %0d: wr_en=%b drop=%b done=%b busy=%b, want wr_en=%b drop=%b done=%b busy=%b",
                 c, bus.mt_wr_en, bus.dropped_flush, bus.done, bus.busy, ew, (c >= 5), (c == 9), (c <= 9));
      end
      if (ew != '0) begin
        vectors++;
        if (bus.mt_wr_idx !== exp_idx(c - 1) || bus.mt_wr_pr !== exp_pr(c - 1, 63, 1'b1)) begin
          miscompares++;
          $display("FAIL drop_data cyc %0d: idx=%h pr=%h, want idx=%h pr=%h",
                   c, bus.mt_wr_idx, bus.mt_wr_pr, exp_idx(c - 1), exp_pr(c - 1, 63, 1'b1));
        end
      end
      tick();
    end
    bus.flush_req = 1'b0;
  endtask

  // Reset at blk=5 returns to IDLE; a fresh flush then restores all 8 blocks.
  task automatic test_reset_mid();
    logic [CW-1:0] ew;
    for (int k = 0; k < NUM_ARCH; k++) bus.arch_map_in[k] = TW'(k + 1);
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    #1;
    vectors++;
    if (bus.mt_wr_en !== '1 || bus.mt_wr_idx !== exp_idx(5)) begin
      miscompares++;
      $display("FAIL rst_pre: wr_en=%b idx=%h, want wr_en=1111 idx=%h", bus.mt_wr_en, bus.mt_wr_idx, exp_idx(5));
    end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if (bus.mt_wr_en !== '0 || bus.mt_wr_idx !== '0 || bus.mt_wr_pr !== '0 || bus.busy !== 1'b0 ||
        bus.stall_dispatch !== 1'b0 || bus.done !== 1'b0 || bus.dropped_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: wr_en=%b idx=%h pr=%h busy=%b stall=%b done=%b drop=%b, want all 0",
               bus.mt_wr_en, bus.mt_wr_idx, bus.mt_wr_pr, bus.busy, bus.stall_dispatch, bus.done, bus.dropped_flush);
    end
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
    for (int c = 0; c < 11; c++) begin
      #1;
      ew = (c >= 1 && c <= 8) ? '1 : '0;
      vectors++;
      if (bus.mt_wr_en !== ew || bus.done !== (c == 9) ||
          (ew != '0 && (bus.mt_wr_idx !== exp_idx(c - 1) || bus.mt_wr_pr !== exp_pr(c - 1, 1, 1'b0)))) begin
        miscompares++;
        $display("FAIL rst_recopy cyc %0d: wr_en=%b done=%b idx=%h pr=%h, want wr_en=%b done=%b",
                 c, bus.mt_wr_en, bus.done, bus.mt_wr_idx, bus.mt_wr_pr, ew, (c == 9));
      end
      tick();
    end
  endtask

  // Flush in the same cycle as done is dropped and does not restart.
  task automatic test_back_to_back();
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    bus.flush_req = 1'b1;
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.dropped_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done: done=%b drop=%b, want done=1 drop=0", bus.done, bus.dropped_flush);
    end
    tick(); bus.flush_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.stall_dispatch !== 1'b0 || bus.dropped_flush !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_after cyc %0d: busy=%b stall=%b drop=%b, want busy=0 stall=0 drop=1",
                 c, bus.busy, bus.stall_dispatch, bus.dropped_flush);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_en_stall();
    test_dropped();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
